mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between instruction fetch (IF) and data access (MEM) of the pipelined 16-bit CPU.
- Sits between the two pipeline memory clients and the external memory model.
- Data requests have priority, since the MEM-stage instruction is older. A starvation guard bounds how long fetch can be locked out.
- Pipeline stall logic consumes `i_done`, `d_done` and `busy`.

Parameters:
- WORD_WIDTH, 16, width of data and instruction words.
- ADDR_WIDTH, 16, width of memory addresses.
- STARVE_LIMIT, 3, consecutive contended D grants before I is forced; 0 = pure data priority.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request; held high with stable i_addr until i_done
- i_addr  in  ADDR_WIDTH  fetch address
- i_rdata  out  WORD_WIDTH  fetched word, registered, valid when i_done=1, held afterwards
- i_done  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request; held high with stable d_we/d_addr/d_wdata until d_done
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  WORD_WIDTH  store data
- d_rdata  out  WORD_WIDTH  load data, registered, valid when d_done=1, held afterwards
- d_done  out  1  one-cycle completion pulse for data
- mem_req  out  1  memory access active
- mem_we  out  1  write enable to memory
- mem_addr  out  ADDR_WIDTH  latched address
- mem_wdata  out  WORD_WIDTH  latched store data
- mem_rdata  in  WORD_WIDTH  memory read data, valid with mem_ready
- mem_ready  in  1  memory completes the access this cycle
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (asynchronous):
  - state=IDLE.
  - mem_req, mem_we, i_done, d_done, busy = 0.
  - mem_addr, mem_wdata, i_rdata, d_rdata = 0.
  - starve_cnt = 0.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - Effective requests: ei = i_req & ~i_done, ed = d_req & ~d_done. A requester is masked in its own done cycle.
  - ed & ~ei -> grant D.
  - ei & ~ed -> grant I.
  - Both set -> grant I if STARVE_LIMIT != 0 and starve_cnt == STARVE_LIMIT; otherwise grant D.
  - No request -> stay IDLE.
- Grant at edge:
  - Latch mem_addr.
  - For D, also latch mem_we=d_we and mem_wdata=d_wdata.
  - For I, set mem_we=0 and mem_wdata=0.
  - Set mem_req=1 and move to BUSY_x.
- BUSY_x:
  - mem_req stays high and mem_* stay stable.
  - mem_ready=0 -> stay.
  - mem_ready=1 -> at the edge: clear mem_req and mem_we, go to IDLE, assert x_done for exactly one cycle.
  - On a read, also capture mem_rdata into x_rdata at the same edge. On a write, d_rdata is unchanged.
- Latency:
  - Request visible in IDLE cycle N.
  - mem_req high from N+1.
  - mem_ready in cycle M>=N+1 gives done in cycle M+1.
  - Minimum request-to-done is 2 cycles.
  - Back-to-back grants are separated by at least one IDLE cycle, which is the done cycle.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each D grant made while ei=1.
  - Clears on every I grant.
  - Unchanged on an uncontended D grant.
  - Width is $clog2(STARVE_LIMIT+1), minimum 1.
- Boundary conditions:
  - mem_ready while IDLE is ignored: no done, no capture.
  - Request deasserted mid-BUSY is a protocol violation; the access still completes and done still pulses.
  - Simultaneous done of one client and a new request of the other is arbitrated normally in that IDLE cycle.
  - Reset mid-BUSY aborts immediately: mem_req drops asynchronously, no done pulse. The memory model tolerates the abort.

Decomposition:
- Shared header holds the FSM state encodings (IDLE=2'b00, BUSY_I=2'b01, BUSY_D=2'b10) and the WORD_WIDTH/ADDR_WIDTH defaults used by the CPU top.
- One natural sub-module, `starve_counter`:
  - Inputs: clk, reset, inc, clr.
  - Output: at_limit.
  - Parameterised by STARVE_LIMIT.

Test Plan:
1. i_req=1, i_addr=0x0010; mem_ready on 2nd BUSY cycle, mem_rdata=0xA5A5 -> mem_addr=0x0010 and mem_req high exactly 2 cycles, mem_we=0; i_done pulses once; i_rdata=0xA5A5.
2. i_req and d_req (read, 0x0020) rise together; mem_ready=1 every cycle -> D served first (d_done, d_rdata=mem_rdata), then I (mem_addr=0x0010); busy low only in done cycles.
3. STARVE_LIMIT=2; d_req held with new address after each d_done, i_req held -> grant order D,D,I,D,D,I; starve_cnt returns to 0 after each I grant.
4. d_we=1, d_addr=0x0030, d_wdata=0x1234 -> mem_we=1, mem_wdata=0x1234 for the whole access; d_done pulses; d_rdata keeps prior value 0x0000.
5. reset asserted in BUSY_D before mem_ready -> mem_req, busy and done go to 0 immediately; after release, an i_req completes with normal 2-cycle minimum latency.
6. mem_ready=1, mem_rdata=0xFFFF with no requests for 5 cycles -> no done pulses; i_rdata and d_rdata stay 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared arbiter types: FSM state encoding, default bus widths, and a helper that sizes the starvation counter.
package mem_port_arbiter_pkg;

  localparam int unsigned WORD_WIDTH_DEF = 16;
  localparam int unsigned ADDR_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10
  } arb_state_t;

  // A limit of 0 still needs a 1-bit register, so the width never drops to zero.
  function automatic int unsigned starve_cnt_width(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of contended data grants; at_limit tells the arbiter to let fetch in next.
// Updates on the clock edge after inc/clr; clr wins over inc; no backpressure.
module starve_counter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);
  import mem_port_arbiter_pkg::*;

  localparam int unsigned CNT_W = starve_cnt_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIMIT)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign at_limit = (cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data; data wins unless fetch has been starved.
// Request-to-done is 2 cycles minimum; clients wait on *_done while the memory stalls via mem_ready.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned WORD_WIDTH   = WORD_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [WORD_WIDTH-1:0] i_rdata,
  output logic                  i_done,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [WORD_WIDTH-1:0] d_wdata,
  output logic [WORD_WIDTH-1:0] d_rdata,
  output logic                  d_done,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  busy
);

  arb_state_t state, state_nxt;
  logic       ei, ed;
  logic       grant_i, grant_d;
  logic       at_limit, force_i;

  // A client is masked in its own done cycle so a still-high request is not re-granted.
  assign ei      = i_req & ~i_done;
  assign ed      = d_req & ~d_done;
  assign force_i = (STARVE_LIMIT != 0) && at_limit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (ed && !(ei && force_i)) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
        end else if (ei) begin
          grant_i   = 1'b1;
          state_nxt = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .inc     (grant_d & ei),
    .clr     (grant_i),
    .at_limit(at_limit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (grant_i) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= i_addr;
        mem_wdata <= '0;
      end else if (mem_ready) begin
        case (state)
          BUSY_I: begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            i_done  <= 1'b1;
            i_rdata <= mem_rdata;
          end
          BUSY_D: begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            d_done  <= 1'b1;
            // Stores leave the last load result visible.
            if (!mem_we) d_rdata <= mem_rdata;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level expectation model.
module tb_mem_port_arbiter;
  localparam int unsigned LIM = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we, mem_ready;
  logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        i_done, d_done, mem_req, mem_we, busy;

  int          tests = 0;
  int          fails = 0;
  int          model_cnt, lat, kind;
  bit          exp_i, rdy, got_done;
  logic [15:0] addr, wd, rd, exp_ir, exp_dr;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .WORD_WIDTH  (16),
    .ADDR_WIDTH  (16),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_done   (i_done),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_done   (d_done),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .busy     (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    tick(); tick();
    chk("rst_ctrl", {mem_req, mem_we, busy, i_done, d_done}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", {i_rdata, d_rdata}, 0);
    chk("rst_starve_cnt", dut.u_starve.cnt, 0);
    reset = 1'b0;
    tick();

    // mem_ready while idle must be ignored
    mem_ready = 1'b1; mem_rdata = 16'hFFFF;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("idle_ready_done", {i_done, d_done, busy, mem_req}, 0);
    end
    chk("idle_ready_i_rdata", i_rdata, 0);
    chk("idle_ready_d_rdata", d_rdata, 0);
    mem_ready = 1'b0;

    // single fetch, ready on the second busy cycle
    i_req = 1'b1; i_addr = 16'h0010;
    tick();
    chk("t1_req_c1", {mem_req, mem_we}, 2'b10);
    chk("t1_addr", mem_addr, 16'h0010);
    tick();
    chk("t1_req_c2", {mem_req, i_done}, 2'b10);
    mem_ready = 1'b1; mem_rdata = 16'hA5A5;
    tick();
    chk("t1_done", {i_done, d_done, mem_req}, 3'b100);
    chk("t1_rdata", i_rdata, 16'hA5A5);
    i_req = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    tick();
    chk("t1_done_once", {i_done, mem_req, busy}, 0);
    chk("t1_rdata_held", i_rdata, 16'hA5A5);

    // store: d_rdata keeps its old value
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0030; d_wdata = 16'h1234;
    tick();
    chk("t4_we_c1", {mem_req, mem_we}, 2'b11);
    chk("t4_addr", mem_addr, 16'h0030);
    chk("t4_wdata_c1", mem_wdata, 16'h1234);
    tick();
    chk("t4_we_c2", {mem_req, mem_we}, 2'b11);
    chk("t4_wdata_c2", mem_wdata, 16'h1234);
    mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    chk("t4_done", {d_done, i_done, mem_req, mem_we}, 4'b1000);
    chk("t4_rdata_kept", d_rdata, 16'h0000);
    d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    tick();
    chk("t4_done_once", d_done, 0);

    // simultaneous requests: data first, then fetch in the data done cycle
    i_req = 1'b1; i_addr = 16'h0010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
    mem_ready = 1'b1; mem_rdata = 16'h1111;
    tick();
    chk("t2_d_first", mem_addr, 16'h0020);
    chk("t2_busy_d", busy, 1);
    tick();
    chk("t2_d_done", {d_done, i_done, busy}, 3'b100);
    chk("t2_d_rdata", d_rdata, 16'h1111);
    d_req = 1'b0; mem_rdata = 16'h2222;
    tick();
    chk("t2_i_second", mem_addr, 16'h0010);
    chk("t2_busy_i", busy, 1);
    tick();
    chk("t2_i_done", {i_done, d_done, busy}, 3'b100);
    chk("t2_i_rdata", i_rdata, 16'h2222);
    i_req = 1'b0; mem_ready = 1'b0;
    tick();
    chk("t2_quiet", {busy, mem_req}, 0);

    // starvation guard: both requesters contend in a clean idle cycle each round
    model_cnt = 0;
    for (int g = 0; g < 6; g++) begin
      i_req = 1'b1; i_addr = 16'h0010;
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040 + 16'(g);
      mem_ready = 1'b0;
      exp_i = (model_cnt == int'(LIM));
      tick();
      chk("t3_grant_order", mem_addr, exp_i ? 16'h0010 : 16'h0040 + 16'(g));
      model_cnt = exp_i ? 0 : ((model_cnt < int'(LIM)) ? model_cnt + 1 : int'(LIM));
      chk("t3_starve_cnt", dut.u_starve.cnt, model_cnt);
      if (exp_i) d_req = 1'b0;
      else i_req = 1'b0;
      mem_ready = 1'b1; mem_rdata = 16'(g);
      tick();
      chk("t3_done", {i_done, d_done}, exp_i ? 2'b10 : 2'b01);
      i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
      tick();
    end

    // reset in the middle of a data access
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0050;
    tick();
    chk("t5_busy_before", {mem_req, busy}, 2'b11);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_abort", {mem_req, busy, d_done, i_done}, 0);
    d_req = 1'b0;
    tick(); tick();
    chk("t5_no_done", {d_done, mem_req}, 0);
    reset = 1'b0;
    i_req = 1'b1; i_addr = 16'h0060; mem_ready = 1'b1; mem_rdata = 16'h0F0F;
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (i_done) begin
        lat = c;
        break;
      end
    end
    chk("t5_latency", lat, 2);
    chk("t5_rdata", i_rdata, 16'h0F0F);
    chk("t5_d_rdata_cleared", d_rdata, 0);
    i_req = 1'b0; mem_ready = 1'b0;
    tick();

    // randomized single-client accesses with random memory latency
    exp_ir = 16'h0F0F;
    exp_dr = 16'h0000;
    for (int t = 0; t < 24; t++) begin
      kind = $urandom_range(0, 2);
      addr = 16'($urandom);
      wd   = 16'($urandom);
      if (kind == 0) begin
        i_req = 1'b1; i_addr = addr;
      end else begin
        d_req = 1'b1; d_we = (kind == 2); d_addr = addr; d_wdata = wd;
      end
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = 16'($urandom);
      tick();
      chk("rnd_grant_addr", mem_addr, addr);
      chk("rnd_grant_we", {mem_req, mem_we}, {1'b1, kind == 2});
      if (kind == 2) chk("rnd_grant_wdata", mem_wdata, wd);
      got_done = 1'b0;
      for (int c = 0; c < 16 && !got_done; c++) begin
        rdy = (c == 15) ? 1'b1 : ($urandom_range(0, 2) == 0);
        rd  = 16'($urandom);
        mem_ready = rdy; mem_rdata = rd;
        tick();
        if (rdy) begin
          got_done = 1'b1;
          if (kind == 0) begin
            exp_ir = rd;
            chk("rnd_i_done", {i_done, d_done}, 2'b10);
          end else begin
            if (kind == 1) exp_dr = rd;
            chk("rnd_d_done", {i_done, d_done}, 2'b01);
          end
          chk("rnd_i_rdata", i_rdata, exp_ir);
          chk("rnd_d_rdata", d_rdata, exp_dr);
        end else begin
          chk("rnd_hold", {mem_req, i_done, d_done}, 3'b100);
          chk("rnd_hold_addr", mem_addr, addr);
        end
      end
      i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = 16'($urandom);
      tick();
      chk("rnd_idle_after", {i_done, d_done, busy}, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
